play_core: RTL and testbench
============================

PLAY_CORE -- requirements
Module: play_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample-word buffer depth; power of 2, minimum 2.
REQ-002 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have ports play_start in 1 (start pulse from controller) and play_stop in 1 (abort pulse).
REQ-005 SHALL have ports play_start_addr in 23 (first SDRAM word address) and play_length in 23 (word count); both sampled on accepted start.
REQ-006 SHALL have ports play_busy out 1 (operation active) and play_done out 1 (one-cycle completion pulse).
REQ-007 SHALL have SDRAM-side ports play_read out 1, play_addr out 23, play_readdata in 32, play_read_finished in 1 (one-cycle pulse; play_readdata valid in that cycle).
REQ-008 SHALL have ports to_dac_left_channel_data out 16, to_dac_left_channel_valid out 1, to_dac_left_channel_ready in 1, and the same three for the right channel.

Function
REQ-009 SHALL implement FSM IDLE, FETCH, DRAIN, DONE.
REQ-010 IDLE: play_start asserted -> latch addr/length; length 0 -> DONE, else FETCH.
REQ-011 FETCH: assert play_read with stable play_addr only when FIFO free slots > 0; at most one read outstanding.
REQ-012 play_read SHALL stay high until play_read_finished; on finished: readdata written to FIFO, play_read low for the following cycle, addr +1, remaining -1.
REQ-013 Address SHALL wrap 0x7FFFFF -> 0x000000.
REQ-014 FETCH -> DRAIN when remaining reaches 0; DRAIN -> DONE when FIFO empty and no partial word pending.
REQ-015 DONE SHALL last one cycle with play_done=1, then IDLE; play_busy=1 in FETCH, DRAIN, DONE.
REQ-016 Stereo word format: [31:16] left sample, [15:0] right sample.
REQ-017 Both channel valids SHALL be high while the FIFO head is unconsumed; data = head fields; first valid one cycle after play_read_finished.
REQ-018 Per-channel accepted flag set on valid&ready; that channel's valid drops until pop; head popped when both accepted (same or different cycles); flags then cleared.
REQ-019 FIFO write and pop in the same cycle SHALL be allowed, occupancy unchanged; full FIFO SHALL block new reads, never drop data.
REQ-020 play_stop in FETCH/DRAIN: if a read is outstanding, wait for play_read_finished and discard the data; then flush FIFO and flags, go to DONE.
REQ-021 play_start while busy SHALL be ignored; play_stop in IDLE or DONE ignored; start and stop together in IDLE -> start accepted.

Reset
REQ-022 i_rst SHALL force IDLE; play_read, play_busy, play_done, both valids 0; play_addr and both data outputs 0x0; FIFO empty; flags cleared.
REQ-023 Reset mid-read SHALL abandon the read; a play_read_finished arriving after reset SHALL be ignored.

Configuration
REQ-024 With PLAY_MONO_EN defined: each word holds two mono samples, [31:16] first then [15:0]; each sample drives both channels; two pops-of-half per word; word freed after second half accepted.
REQ-025 Without PLAY_MONO_EN: stereo format per REQ-016, one output beat per word.

Verification
REQ-026 start addr 0x000100, length 3, readdata 0x11112222/0x33334444/0x55556666, ready=1 -> reads at 0x100-0x102, L/R 0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666, play_done once.
REQ-027 length 0 -> play_done one cycle after start; play_read never asserted.
REQ-028 start addr 0x7FFFFE, length 3 -> play_addr 0x7FFFFE, 0x7FFFFF, 0x000000.
REQ-029 ready low, length 20, FIFO_DEPTH 8 -> reads stall after 8 words; left-ready then right-ready a cycle later pops one word, one new read.
REQ-030 play_stop while read outstanding -> returned word never on DAC; valids low after flush; play_done pulse; next start works.
REQ-031 PLAY_MONO_EN, word 0xAAAA5555 -> both channels 0xAAAA, then both 0x5555.

Source files
------------

// File: rtl/play_core.sv
// SDRAM playback engine: fetches a block of 32-bit words into a small FIFO and streams them to a stereo DAC.
// Define PLAY_MONO_EN to treat each word as two consecutive mono samples that drive both channels.
module play_core #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        play_start,
    input  logic        play_stop,
    input  logic [22:0] play_start_addr,
    input  logic [22:0] play_length,
    output logic        play_busy,
    output logic        play_done,
    output logic        play_read,
    output logic [22:0] play_addr,
    input  logic [31:0] play_readdata,
    input  logic        play_read_finished,
    output logic [15:0] to_dac_left_channel_data,
    output logic        to_dac_left_channel_valid,
    input  logic        to_dac_left_channel_ready,
    output logic [15:0] to_dac_right_channel_data,
    output logic        to_dac_right_channel_valid,
    input  logic        to_dac_right_channel_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_read;
    logic [22:0] r_addr;
    logic [22:0] r_remaining;
    logic        r_stop;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_acc_l;
    logic        r_acc_r;
`ifdef PLAY_MONO_EN
    logic        r_half;
`endif

    logic        w_active;
    logic        w_stop_req;
    logic        w_rd_done;
    logic        w_abort;
    logic        w_push;
    logic        w_pop;
    logic        w_issue;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic [31:0] w_head;
    logic        w_valid_l;
    logic        w_valid_r;
    logic        w_take_l;
    logic        w_take_r;
    logic        w_both;

    assign w_active   = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_stop_req = w_active && (r_stop || play_stop);
    assign w_rd_done  = r_read && play_read_finished;
    // A stop with a read in flight waits for its completion; that word is thrown away.
    assign w_abort    = w_stop_req && (!r_read || play_read_finished);
    assign w_push     = w_rd_done && !w_stop_req;
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_issue    = (r_state == S_FETCH) && !r_read && !w_stop_req
                        && (r_remaining != '0) && !w_full;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    assign w_valid_l  = !w_empty && !r_acc_l;
    assign w_valid_r  = !w_empty && !r_acc_r;
    assign w_take_l   = r_acc_l || (w_valid_l && to_dac_left_channel_ready);
    assign w_take_r   = r_acc_r || (w_valid_r && to_dac_right_channel_ready);
    assign w_both     = !w_empty && w_take_l && w_take_r;
`ifdef PLAY_MONO_EN
    assign w_pop      = w_both && r_half;
`else
    assign w_pop      = w_both;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (play_start) begin
                    w_state_nxt = (play_length == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_abort) begin
                    w_state_nxt = S_DONE;
                end else if (w_rd_done && (r_remaining == 23'd1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort || w_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        play_busy                  = (r_state != S_IDLE);
        play_done                  = (r_state == S_DONE);
        play_read                  = r_read;
        play_addr                  = r_addr;
        to_dac_left_channel_valid  = w_valid_l;
        to_dac_right_channel_valid = w_valid_r;
        to_dac_left_channel_data   = '0;
        to_dac_right_channel_data  = '0;
        if (!w_empty) begin
`ifdef PLAY_MONO_EN
            to_dac_left_channel_data  = r_half ? w_head[15:0] : w_head[31:16];
            to_dac_right_channel_data = r_half ? w_head[15:0] : w_head[31:16];
`else
            to_dac_left_channel_data  = w_head[31:16];
            to_dac_right_channel_data = w_head[15:0];
`endif
        end
    end

    // Read request and address/length bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_read      <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_stop      <= 1'b0;
        end else begin
            r_stop <= w_stop_req && !w_abort;
            if (w_rd_done) begin
                r_read <= 1'b0;
            end else if (w_issue) begin
                r_read <= 1'b1;
            end
            if ((r_state == S_IDLE) && play_start) begin
                r_addr      <= play_start_addr;
                r_remaining <= play_length;
            end else if (w_rd_done) begin
                r_addr      <= r_addr + 23'd1;
                r_remaining <= r_remaining - 23'd1;
            end
        end
    end

    // FIFO pointers and per-channel acceptance tracking
    always_ff @(posedge i_clk) begin
        if (i_rst || w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_acc_l  <= 1'b0;
            r_acc_r  <= 1'b0;
`ifdef PLAY_MONO_EN
            r_half   <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_both) begin
                r_acc_l <= 1'b0;
                r_acc_r <= 1'b0;
`ifdef PLAY_MONO_EN
                r_half  <= !r_half;
`endif
            end else begin
                r_acc_l <= w_take_l;
                r_acc_r <= w_take_r;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= play_readdata;
        end
    end

endmodule

// File: tb/tb_play_core.sv
// Directed bench for play_core: transfers, zero length, address wrap, backpressure, stop and reset.
module tb_play_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play_start = 1'b0;
    logic        play_stop = 1'b0;
    logic [22:0] play_start_addr = '0;
    logic [22:0] play_length = '0;
    logic        play_busy;
    logic        play_done;
    logic        play_read;
    logic [22:0] play_addr;
    logic [31:0] play_readdata = '0;
    logic        play_read_finished = 1'b0;
    logic [15:0] dl;
    logic        vl;
    logic        rdy_l = 1'b0;
    logic [15:0] dr;
    logic        vr;
    logic        rdy_r = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    play_core #(.FIFO_DEPTH(8)) dut (
        .i_clk                      (clk),
        .i_rst                      (rst),
        .play_start                 (play_start),
        .play_stop                  (play_stop),
        .play_start_addr            (play_start_addr),
        .play_length                (play_length),
        .play_busy                  (play_busy),
        .play_done                  (play_done),
        .play_read                  (play_read),
        .play_addr                  (play_addr),
        .play_readdata              (play_readdata),
        .play_read_finished         (play_read_finished),
        .to_dac_left_channel_data   (dl),
        .to_dac_left_channel_valid  (vl),
        .to_dac_left_channel_ready  (rdy_l),
        .to_dac_right_channel_data  (dr),
        .to_dac_right_channel_valid (vr),
        .to_dac_right_channel_ready (rdy_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (play_read) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Hold the request one extra cycle, then complete it with data.
    task automatic finish_read(input logic [31:0] d);
        tick();
        play_readdata      = d;
        play_read_finished = 1'b1;
        tick();
        play_read_finished = 1'b0;
        play_readdata      = '0;
    endtask

    task automatic start_op(input logic [22:0] a, input logic [22:0] n);
        play_start_addr = a;
        play_length     = n;
        play_start      = 1'b1;
        tick();
        play_start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({play_read, play_busy, play_done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000", {play_read, play_busy, play_done});
        end
        n_vec++;
        if ({vl, vr} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 00", {vl, vr});
        end
        n_vec++;
        if (play_addr !== 23'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h want 000000", play_addr);
        end
        n_vec++;
        if ({dl, dr} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 00000000", {dl, dr});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] d [3];
        bit ok;
        int ndone;
        d[0] = 32'h11112222;
        d[1] = 32'h33334444;
        d[2] = 32'h55556666;
        rdy_l = 1'b1;
        rdy_r = 1'b1;
        start_op(23'h000100, 23'd3);
        n_vec++;
        if (play_busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b want 1", play_busy);
        end
        for (int k = 0; k < 3; k++) begin
            wait_read(20, ok);
            n_vec++;
            if (!ok || play_addr !== 23'h000100 + 23'(k)) begin
                n_err++;
                $display("FAIL basic_addr%0d: got ok=%0d addr=%h want addr=%h", k, ok, play_addr,
                         23'h000100 + 23'(k));
            end
            finish_read(d[k]);
            n_vec++;
            if ({vl, vr, dl, dr} !== {2'b11, d[k]}) begin
                n_err++;
                $display("FAIL basic_beat%0d: got v=%b%b %h/%h want 11 %h", k, vl, vr, dl, dr, d[k]);
            end
            n_vec++;
            if (play_read !== 1'b0) begin
                n_err++;
                $display("FAIL basic_read_gap%0d: got %b want 0", k, play_read);
            end
        end
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (play_done) ndone++;
            tick();
        end
        n_vec++;
        if (ndone != 1 || play_busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: got pulses=%0d busy=%b want 1 0", ndone, play_busy);
        end
    endtask

    task automatic test_len0();
        int nread;
        play_stop = 1'b1;
        start_op(23'h000055, 23'd0);
        play_stop = 1'b0;
        n_vec++;
        if ({play_done, play_read, play_busy} !== 3'b101) begin
            n_err++;
            $display("FAIL len0_done: got done/read/busy=%b want 101", {play_done, play_read, play_busy});
        end
        nread = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (play_read || play_done || play_busy) nread++;
        end
        n_vec++;
        if (nread != 0) begin
            n_err++;
            $display("FAIL len0_idle: got %0d active cycles want 0", nread);
        end
    endtask

    task automatic test_wrap();
        logic [22:0] ea [3];
        bit ok;
        int ndone;
        ea[0] = 23'h7FFFFE;
        ea[1] = 23'h7FFFFF;
        ea[2] = 23'h000000;
        rdy_l = 1'b1;
        rdy_r = 1'b1;
        start_op(23'h7FFFFE, 23'd3);
        for (int k = 0; k < 3; k++) begin
            wait_read(20, ok);
            n_vec++;
            if (!ok || play_addr !== ea[k]) begin
                n_err++;
                $display("FAIL wrap_addr%0d: got ok=%0d addr=%h want %h", k, ok, play_addr, ea[k]);
            end
            finish_read(32'h0A0B0C0D);
        end
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (play_done) ndone++;
            tick();
        end
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL wrap_done: got %0d pulses want 1", ndone);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int served;
        rdy_l = 1'b0;
        rdy_r = 1'b0;
        start_op(23'h000200, 23'd20);
        served = 0;
        for (int k = 0; k < 12; k++) begin
            wait_read(20, ok);
            if (!ok) break;
            finish_read({16'hA000 + 16'(k), 16'hB000 + 16'(k)});
            served++;
        end
        n_vec++;
        if (served != 8) begin
            n_err++;
            $display("FAIL bp_stall: got %0d reads want 8", served);
        end
        n_vec++;
        if ({vl, vr, dl, dr} !== {2'b11, 16'hA000, 16'hB000}) begin
            n_err++;
            $display("FAIL bp_head: got v=%b%b %h/%h want 11 a000/b000", vl, vr, dl, dr);
        end
        // A start while busy must not disturb the running transfer.
        start_op(23'h000600, 23'd1);
        rdy_l = 1'b1;
        tick();
        rdy_l = 1'b0;
        n_vec++;
        if ({vl, vr} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_left_acc: got %b want 01", {vl, vr});
        end
        rdy_r = 1'b1;
        tick();
        rdy_r = 1'b0;
        n_vec++;
        if ({vl, vr, dl, dr} !== {2'b11, 16'hA001, 16'hB001}) begin
            n_err++;
            $display("FAIL bp_pop: got v=%b%b %h/%h want 11 a001/b001", vl, vr, dl, dr);
        end
        wait_read(20, ok);
        n_vec++;
        if (!ok || play_addr !== 23'h000208) begin
            n_err++;
            $display("FAIL bp_refill: got ok=%0d addr=%h want addr=000208", ok, play_addr);
        end
        finish_read(32'hA008B008);
        wait_read(20, ok);
        n_vec++;
        if (ok) begin
            n_err++;
            $display("FAIL bp_restall: got read=1 want 0");
        end
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        n_vec++;
        if ({play_done, vl, vr} !== 3'b100) begin
            n_err++;
            $display("FAIL bp_stop: got done/vl/vr=%b want 100", {play_done, vl, vr});
        end
        tick();
    endtask

    task automatic test_stop_outstanding();
        bit ok;
        bit seen;
        int ndone;
        rdy_l = 1'b1;
        rdy_r = 1'b1;
        start_op(23'h000300, 23'd5);
        wait_read(20, ok);
        finish_read(32'h12345678);
        n_vec++;
        if ({vl, vr, dl, dr} !== {2'b11, 32'h12345678}) begin
            n_err++;
            $display("FAIL stop_first: got v=%b%b %h/%h want 11 1234/5678", vl, vr, dl, dr);
        end
        wait_read(20, ok);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        n_vec++;
        if (!ok || {play_read, play_busy, play_done} !== 3'b110) begin
            n_err++;
            $display("FAIL stop_wait: got ok=%0d read/busy/done=%b want 110", ok,
                     {play_read, play_busy, play_done});
        end
        tick();
        play_readdata      = 32'hDEADBEEF;
        play_read_finished = 1'b1;
        tick();
        play_read_finished = 1'b0;
        n_vec++;
        if ({play_done, vl, vr, dl, dr} !== {3'b100, 32'h0}) begin
            n_err++;
            $display("FAIL stop_flush: got done=%b v=%b%b %h/%h want 1 00 0000/0000",
                     play_done, vl, vr, dl, dr);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ((vl && dl == 16'hDEAD) || (vr && dr == 16'hBEEF)) seen = 1'b1;
        end
        n_vec++;
        if (seen || play_busy) begin
            n_err++;
            $display("FAIL stop_discard: got seen=%0d busy=%b want 0 0", seen, play_busy);
        end
        start_op(23'h000400, 23'd1);
        wait_read(20, ok);
        n_vec++;
        if (!ok || play_addr !== 23'h000400) begin
            n_err++;
            $display("FAIL stop_restart_addr: got ok=%0d addr=%h want 000400", ok, play_addr);
        end
        finish_read(32'hCAFEF00D);
        n_vec++;
        if ({vl, vr, dl, dr} !== {2'b11, 32'hCAFEF00D}) begin
            n_err++;
            $display("FAIL stop_restart_data: got v=%b%b %h/%h want 11 cafe/f00d", vl, vr, dl, dr);
        end
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (play_done) ndone++;
            tick();
        end
        n_vec++;
        if (ndone != 1) begin
            n_err++;
            $display("FAIL stop_restart_done: got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_midread();
        bit ok;
        rdy_l = 1'b1;
        rdy_r = 1'b1;
        start_op(23'h000500, 23'd2);
        wait_read(20, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (!ok || {play_read, play_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_abandon: got ok=%0d read/busy=%b want 00", ok, {play_read, play_busy});
        end
        play_readdata      = 32'h11223344;
        play_read_finished = 1'b1;
        tick();
        play_read_finished = 1'b0;
        tick();
        n_vec++;
        if ({vl, vr, play_busy, play_read, play_done} !== 5'b00000) begin
            n_err++;
            $display("FAIL rstmid_late: got vl/vr/busy/read/done=%b want 00000",
                     {vl, vr, play_busy, play_read, play_done});
        end
    endtask

`ifdef PLAY_MONO_EN
    task automatic test_mono();
        bit ok;
        rdy_l = 1'b1;
        rdy_r = 1'b1;
        start_op(23'h000010, 23'd1);
        wait_read(20, ok);
        finish_read(32'hAAAA5555);
        n_vec++;
        if (!ok || {vl, vr, dl, dr} !== {2'b11, 16'hAAAA, 16'hAAAA}) begin
            n_err++;
            $display("FAIL mono_first: got v=%b%b %h/%h want 11 aaaa/aaaa", vl, vr, dl, dr);
        end
        tick();
        n_vec++;
        if ({vl, vr, dl, dr} !== {2'b11, 16'h5555, 16'h5555}) begin
            n_err++;
            $display("FAIL mono_second: got v=%b%b %h/%h want 11 5555/5555", vl, vr, dl, dr);
        end
        tick();
        n_vec++;
        if ({vl, vr} !== 2'b00) begin
            n_err++;
            $display("FAIL mono_freed: got %b want 00", {vl, vr});
        end
        for (int i = 0; i < 4; i++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_len0();
        test_wrap();
`ifdef PLAY_MONO_EN
        test_mono();
`else
        test_basic();
        test_backpressure();
        test_stop_outstanding();
`endif
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
